// File: rtl/uart_transmitter.sv
// Serial transmit side of the lab UART: one start bit, DATA_BITS data bits LSB first,
// one stop bit, each held CLKS_PER_BIT clocks. Line idles high; all outputs registered.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]           state_r,   state_s;
  logic [CNT_W-1:0]     cnt_r,     cnt_s;
  logic [IDX_W-1:0]     idx_r,     idx_s;
  logic [DATA_BITS-1:0] shift_r,   shift_s;
  logic [DATA_BITS-1:0] shifted_s;
  logic                 tx_out_r,  tx_out_s;
  logic                 tx_busy_r, tx_busy_s;
  logic                 tx_done_r, tx_done_s;
  logic                 bit_end_s;

  // Next-state and next-output decode; outputs are computed here and registered below.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    tx_out_s  = tx_out_r;
    tx_busy_s = tx_busy_r;
    tx_done_s = 1'b0;
    shifted_s = shift_r >> 1;
    bit_end_s = (cnt_r == CNT_LAST);

    case (state_r)
      ST_IDLE: begin
        if (tx_start) begin
          state_s   = ST_START;
          shift_s   = tx_data;
          cnt_s     = '0;
          idx_s     = '0;
          tx_out_s  = 1'b0;
          tx_busy_s = 1'b1;
        end else begin
          tx_out_s  = 1'b1;
          tx_busy_s = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s  = ST_DATA;
          cnt_s    = '0;
          idx_s    = '0;
          tx_out_s = shift_r[0];
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s = '0;
          if (idx_r == IDX_LAST) begin
            state_s  = ST_STOP;
            tx_out_s = 1'b1;
          end else begin
            shift_s  = shifted_s;
            idx_s    = idx_r + IDX_ONE;
            tx_out_s = shifted_s[0];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_s     = '0;
          tx_done_s = 1'b1;
          // A pending request chains straight into the next start bit with no idle clock.
          if (tx_start) begin
            state_s   = ST_START;
            shift_s   = tx_data;
            idx_s     = '0;
            tx_out_s  = 1'b0;
            tx_busy_s = 1'b1;
          end else begin
            state_s   = ST_IDLE;
            tx_out_s  = 1'b1;
            tx_busy_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = '0;
        idx_s     = '0;
        tx_out_s  = 1'b1;
        tx_busy_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame and returns the line high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      idx_r     <= '0;
      shift_r   <= '0;
      tx_out_r  <= 1'b1;
      tx_busy_r <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      shift_r   <= shift_s;
      tx_out_r  <= tx_out_s;
      tx_busy_r <= tx_busy_s;
      tx_done_r <= tx_done_s;
    end
  end

  assign tx_out  = tx_out_r;
  assign tx_busy = tx_busy_r;
  assign tx_done = tx_done_r;

endmodule
